// File: rtl/serial_feeder_pkg.sv
// Shared constants for the serial feeder and its downstream detector bench.
// State encoding, default word width and the idle line level live here.
package serial_feeder_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam int   DEF_WIDTH    = 8;
   localparam logic DEF_IDLE_BIT = 1'b0;

endpackage

// File: rtl/serial_feeder_if.sv
// Load/ready handshake plus serial-side status of the feeder.
// master = word producer, slave = the feeder itself.
interface serial_feeder_if #(
   parameter int WIDTH = serial_feeder_pkg::DEF_WIDTH
);
   logic [WIDTH-1:0] Data;
   logic             Load;
   logic             Ready;
   logic             w;
   logic             Busy;
   logic             Word_done;
   logic             Overrun;

   modport master (
      output Data, Load,
      input  Ready, w, Busy, Word_done, Overrun
   );

   modport slave (
      input  Data, Load,
      output Ready, w, Busy, Word_done, Overrun
   );
endinterface

// File: rtl/serial_feeder.sv
// Parallel-to-serial feeder: loads WIDTH-bit words on Load & Ready and emits
// them one bit per clock on w, streaming back-to-back words without a gap.
module serial_feeder
   import serial_feeder_pkg::*;
#(
   parameter int   WIDTH     = DEF_WIDTH,
   parameter int   LSB_FIRST = 0,
   parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
   input  logic           Clock,
   input  logic           Reset,
   serial_feeder_if.slave bus
);

   localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] sr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovr_q;

   logic last_bit, ready, accept;

   assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST);
   assign ready    = (state_q == ST_IDLE) || (cnt_q == LAST);
   assign accept   = bus.Load && ready;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  sr_q    <= bus.Data;
                  cnt_q   <= '0;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (cnt_q == LAST) begin
                  // Reload on the last bit so the next word follows with no gap
                  if (accept) begin
                     sr_q  <= bus.Data;
                     cnt_q <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  if (LSB_FIRST != 0) sr_q <= sr_q >> 1;
                  else                sr_q <= sr_q << 1;
                  cnt_q <= cnt_q + 1'b1;
                  if (bus.Load) ovr_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.Ready     = ready;
   assign bus.Busy      = (state_q == ST_SHIFT);
   assign bus.Word_done = last_bit;
   assign bus.Overrun   = ovr_q;
   assign bus.w         = (state_q == ST_SHIFT)
                          ? ((LSB_FIRST != 0) ? sr_q[0] : sr_q[WIDTH-1])
                          : IDLE_BIT;

endmodule

// File: tb/tb_serial_feeder.sv
// Bench for serial_feeder: an 8-bit MSB-first and a 4-bit LSB-first instance
// are compared every cycle against a bit-queue model of the expected line.
module tb_serial_feeder;
   import serial_feeder_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   serial_feeder_if #(.WIDTH(8)) ia ();
   serial_feeder_if #(.WIDTH(4)) ib ();

   serial_feeder #(.WIDTH(8), .LSB_FIRST(0), .IDLE_BIT(DEF_IDLE_BIT)) dut_a (
      .Clock(clk), .Reset(rst), .bus(ia.slave));
   serial_feeder #(.WIDTH(4), .LSB_FIRST(1), .IDLE_BIT(DEF_IDLE_BIT)) dut_b (
      .Clock(clk), .Reset(rst), .bus(ib.slave));

   // Model: queue of bits still to appear on w; head is the bit now on the line
   bit qa[$];
   bit qb[$];
   bit ova, ovb;

   function automatic logic [4:0] exp_a();
      return {(qa.size() > 0) ? logic'(qa[0]) : DEF_IDLE_BIT,
              logic'(qa.size() <= 1), logic'(qa.size() > 0),
              logic'(qa.size() == 1), logic'(ova)};
   endfunction

   function automatic logic [4:0] exp_b();
      return {(qb.size() > 0) ? logic'(qb[0]) : DEF_IDLE_BIT,
              logic'(qb.size() <= 1), logic'(qb.size() > 0),
              logic'(qb.size() == 1), logic'(ovb)};
   endfunction

   function automatic logic [9:0] got_ab();
      return {ia.w, ia.Ready, ia.Busy, ia.Word_done, ia.Overrun,
              ib.w, ib.Ready, ib.Busy, ib.Word_done, ib.Overrun};
   endfunction

   task automatic clear_model();
      qa.delete(); qb.delete(); ova = 0; ovb = 0;
   endtask

   // Advance one clock: model takes the same inputs the DUTs see at the edge
   task automatic step();
      bit ra, rb;
      logic [7:0] da;
      logic [3:0] db;
      @(posedge clk);
      if (!rst) begin
         ra = (qa.size() <= 1); rb = (qb.size() <= 1);
         da = ia.Data; db = ib.Data;
         if (qa.size() > 0) void'(qa.pop_front());
         if (qb.size() > 0) void'(qb.pop_front());
         if (ia.Load) begin
            if (ra) for (int i = 7; i >= 0; i--) qa.push_back(da[i]);
            else    ova = 1;
         end
         if (ib.Load) begin
            if (rb) for (int i = 0; i < 4; i++) qb.push_back(db[i]);
            else    ovb = 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; clear_model();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] g;
      ia.Load = 0; ia.Data = '0; ib.Load = 0; ib.Data = '0;
      clear_model();
      @(negedge clk);
      n_tests++;
      g = got_ab();
      if (g !== 10'b01000_01000) begin
         n_fail++; $display("FAIL reset_state got=%b exp=%b", g, 10'b01000_01000);
      end
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         n_tests++;
         g = got_ab();
         if (g !== {exp_a(), exp_b()} || g !== 10'b01000_01000) begin
            n_fail++; $display("FAIL idle cyc=%0d got=%b exp=%b", c, g, {exp_a(), exp_b()});
         end
      end
      ia.Load = 1; ia.Data = 8'hFF; ib.Load = 1; ib.Data = 4'hF;
      step();
      ia.Load = 0; ib.Load = 0;
      step(); step();
      #2 rst = 1'b1; clear_model();
      #1;
      n_tests++;
      g = got_ab();
      if (g !== 10'b01000_01000) begin
         n_fail++; $display("FAIL async_reset got=%b exp=%b", g, 10'b01000_01000);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [7:0] pat, seen;
      logic [7:0] wd;
      logic [9:0] g;
      pat = 8'b1101_0000;
      ia.Load = 1; ia.Data = pat;
      for (int c = 0; c < 10; c++) begin
         step();
         ia.Load = 0; ia.Data = $urandom;
         g = got_ab();
         n_tests++;
         if (g !== {exp_a(), exp_b()}) begin
            n_fail++; $display("FAIL single cyc=%0d got=%b exp=%b", c + 1, g, {exp_a(), exp_b()});
         end
         if (c < 8) begin
            seen[7-c] = ia.w; wd[7-c] = ia.Word_done;
         end
      end
      n_tests++;
      if (seen !== pat || wd !== 8'b0000_0001) begin
         n_fail++; $display("FAIL single_stream w=%b exp=%b done=%b exp=00000001", seen, pat, wd);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] seen, busy, wd;
      logic [9:0]  g;
      for (int i = 0; i < 16; i++) begin
         if (i == 0) begin ia.Load = 1; ia.Data = 8'hA5; end
         if (i == 1) ia.Data = 8'h3C;
         if (i == 9) ia.Load = 0;
         step();
         g = got_ab();
         n_tests++;
         if (g !== {exp_a(), exp_b()}) begin
            n_fail++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i + 1, g, {exp_a(), exp_b()});
         end
         seen[15-i] = ia.w; busy[15-i] = ia.Busy; wd[15-i] = ia.Word_done;
      end
      n_tests++;
      if (seen !== 16'hA53C || busy !== 16'hFFFF || wd !== 16'h0101) begin
         n_fail++; $display("FAIL b2b_stream w=%h exp=a53c busy=%h exp=ffff done=%h exp=0101",
                            seen, busy, wd);
      end
   endtask

   task automatic test_overrun();
      logic [7:0] seen;
      logic [9:0] g;
      do_reset();
      ia.Load = 1; ia.Data = 8'h5A;
      for (int c = 0; c < 14; c++) begin
         step();
         ia.Load = (c == 2); ia.Data = (c == 2) ? 8'hFF : 8'h00;
         g = got_ab();
         n_tests++;
         if (g !== {exp_a(), exp_b()}) begin
            n_fail++; $display("FAIL overrun cyc=%0d got=%b exp=%b", c + 1, g, {exp_a(), exp_b()});
         end
         if (c < 8) seen[7-c] = ia.w;
         if (c >= 3) begin
            n_tests++;
            if (ia.Overrun !== 1'b1) begin
               n_fail++; $display("FAIL overrun_sticky cyc=%0d got=%b exp=1", c + 1, ia.Overrun);
            end
         end
      end
      n_tests++;
      if (seen !== 8'h5A) begin
         n_fail++; $display("FAIL overrun_stream w=%h exp=5a", seen);
      end
   endtask

   task automatic test_lsb_first();
      logic [3:0] seen;
      logic [9:0] g;
      do_reset();
      ib.Load = 1; ib.Data = 4'b1011;
      for (int c = 0; c < 6; c++) begin
         step();
         ib.Load = 0;
         g = got_ab();
         n_tests++;
         if (g !== {exp_a(), exp_b()}) begin
            n_fail++; $display("FAIL lsb cyc=%0d got=%b exp=%b", c + 1, g, {exp_a(), exp_b()});
         end
         if (c < 4) seen[3-c] = ib.w;
      end
      n_tests++;
      if (seen !== 4'b1101) begin
         n_fail++; $display("FAIL lsb_stream w=%b exp=1101", seen);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] seen;
      logic [9:0] g;
      ia.Load = 1; ia.Data = 8'hFF; ib.Load = 1; ib.Data = 4'hF;
      step();
      ia.Load = 0; ib.Load = 0;
      step(); step(); step();
      #2 rst = 1'b1; clear_model();
      #1;
      g = got_ab();
      n_tests++;
      if (g !== 10'b01000_01000) begin
         n_fail++; $display("FAIL midword_reset got=%b exp=%b", g, 10'b01000_01000);
      end
      @(negedge clk);
      rst = 1'b0;
      ia.Load = 1; ia.Data = 8'h81;
      for (int c = 0; c < 9; c++) begin
         step();
         ia.Load = 0;
         g = got_ab();
         n_tests++;
         if (g !== {exp_a(), exp_b()}) begin
            n_fail++; $display("FAIL after_reset cyc=%0d got=%b exp=%b", c + 1, g, {exp_a(), exp_b()});
         end
         if (c < 8) seen[7-c] = ia.w;
      end
      n_tests++;
      if (seen !== 8'h81) begin
         n_fail++; $display("FAIL after_reset_stream w=%h exp=81", seen);
      end
   endtask

   task automatic test_random();
      logic [9:0] g;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         ia.Load = ($urandom_range(0, 99) < 35); ia.Data = $urandom;
         ib.Load = ($urandom_range(0, 99) < 45); ib.Data = $urandom;
         if (c == 200) begin
            ia.Load = 0; ib.Load = 0;
            do_reset();
         end
         step();
         g = got_ab();
         n_tests++;
         if (g !== {exp_a(), exp_b()}) begin
            n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", c, g, {exp_a(), exp_b()});
         end
      end
      ia.Load = 0; ib.Load = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_lsb_first();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
